// File: rtl/fp_addsub_arbiter_if.sv
// Bundle for the fp_addsub_arbiter: two requesters, the shared fadd/fsub unit
// operands/results, and the tagged response stream.
interface fp_addsub_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_op1;
    logic [WIDTH-1:0] req0_op2;
    logic [WIDTH-1:0] req1_op1;
    logic [WIDTH-1:0] req1_op2;
    logic             req0_sub;
    logic             req1_sub;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] fpu_op1;
    logic [WIDTH-1:0] fpu_op2;
    logic [WIDTH-1:0] fadd_result;
    logic [WIDTH-1:0] fsub_result;
    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             busy;

    // Environment side: requesters plus the shared arithmetic units.
    modport master (
        output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
               req0_sub, req1_sub, fadd_result, fsub_result,
        input  req0_ready, req1_ready, fpu_op1, fpu_op2, resp_valid, resp_id,
               resp_data, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
               req0_sub, req1_sub, fadd_result, fsub_result,
        output req0_ready, req1_ready, fpu_op1, fpu_op2, resp_valid, resp_id,
               resp_data, busy
    );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one fadd and one fsub unit between two requesters;
// a LATENCY-deep tag pipe routes each result back to its owner.
module fp_addsub_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned WIDTH   = 32
) (
    input logic                 clk,
    input logic                 reset,
    fp_addsub_arbiter_if.slave  bus
);

    typedef struct packed {
        logic valid;
        logic id;
        logic sub;
    } tag_t;

    tag_t [LATENCY-1:0] tag_q, tag_d;
    logic               last_q, last_d;
    logic               hold_q;
    logic               blocked;
    logic               gnt0, gnt1, grant;
    logic               any_valid;
    tag_t               tail;

    // Outputs stay quiet while reset is low and for one cycle afterwards.
    assign blocked = !reset || hold_q;

    always_comb begin
        gnt0  = !blocked && bus.req0_valid && (!bus.req1_valid || last_q);
        gnt1  = !blocked && bus.req1_valid && (!bus.req0_valid || !last_q);
        grant = gnt0 || gnt1;

        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;

        if (gnt0) begin
            bus.fpu_op1 = bus.req0_op1;
            bus.fpu_op2 = bus.req0_op2;
        end else if (gnt1) begin
            bus.fpu_op1 = bus.req1_op1;
            bus.fpu_op2 = bus.req1_op2;
        end else begin
            bus.fpu_op1 = {WIDTH{1'b0}};
            bus.fpu_op2 = {WIDTH{1'b0}};
        end

        last_d = grant ? gnt1 : last_q;

        tag_d           = tag_q;
        tag_d[0].valid  = grant;
        tag_d[0].id     = gnt1;
        tag_d[0].sub    = gnt1 ? bus.req1_sub : (gnt0 && bus.req0_sub);
        for (int i = 1; i < int'(LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            any_valid = any_valid || tag_q[i].valid;
        end
        tail = tag_q[LATENCY-1];

        bus.busy       = !blocked && any_valid;
        bus.resp_valid = !blocked && tail.valid;
        bus.resp_id    = bus.resp_valid && tail.id;
        if (!bus.resp_valid) begin
            bus.resp_data = {WIDTH{1'b0}};
        end else if (tail.sub) begin
            bus.resp_data = bus.fsub_result;
        end else begin
            bus.resp_data = bus.fadd_result;
        end
    end

    // Pointer resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q  <= '0;
            last_q <= 1'b1;
            hold_q <= 1'b1;
        end else begin
            tag_q  <= tag_d;
            last_q <= last_d;
            hold_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed/random bench for fp_addsub_arbiter with a response scoreboard and
// behavioural fadd/fsub units; a second LATENCY=4 instance checks timing.
module tb_fp_addsub_arbiter;

    localparam int unsigned L = 2;

    logic clk;
    logic reset;

    fp_addsub_arbiter_if #(.WIDTH(32)) a ();
    fp_addsub_arbiter_if #(.WIDTH(32)) b ();

    fp_addsub_arbiter #(.LATENCY(L), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    fp_addsub_arbiter #(.LATENCY(4), .WIDTH(32)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in arithmetic: exact for the spec vectors, order-sensitive otherwise.
    function automatic logic [31:0] fadd_f(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
        return x ^ {y[15:0], y[31:16]};
    endfunction

    function automatic logic [31:0] fsub_f(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h4040_0000 && y == 32'h3F80_0000) return 32'h4000_0000;
        return x - y;
    endfunction

    logic [31:0] p1 [L];
    logic [31:0] p2 [L];
    always @(posedge clk) begin
        p1[0] <= a.fpu_op1;
        p2[0] <= a.fpu_op2;
        for (int i = 1; i < int'(L); i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end
    assign a.fadd_result = fadd_f(p1[L-1], p2[L-1]);
    assign a.fsub_result = fsub_f(p1[L-1], p2[L-1]);
    assign b.fadd_result = 32'h1234_5678;
    assign b.fsub_result = 32'h8765_4321;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] data;
    } sb_t;

    sb_t  sb [$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   l4_k   = -1;
    logic m_last = 1'b1;
    logic rst_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] o01, input logic [31:0] o02,
                         input logic s0, input logic v1, input logic [31:0] o11,
                         input logic [31:0] o12, input logic s1);
        a.req0_valid = v0;
        a.req0_op1   = o01;
        a.req0_op2   = o02;
        a.req0_sub   = s0;
        a.req1_valid = v1;
        a.req1_op1   = o11;
        a.req1_op2   = o12;
        a.req1_sub   = s1;
    endtask

    task automatic idle();
        drive(1'b0, 32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 1'b0, 32'hCAFE_0000, 32'hF00D_0000, 1'b1);
    endtask

    // One clock: check at negedge against the model, then advance the model at posedge.
    task automatic tick();
        logic        blk, g0, g1, ev;
        logic [31:0] e1, e2, ed;
        sb_t         e;
        @(negedge clk);
        blk = !reset || rst_seen;
        g0  = 1'b0;
        g1  = 1'b0;
        if (!blk) begin
            if (a.req0_valid && a.req1_valid) begin
                if (m_last) g0 = 1'b1;
                else        g1 = 1'b1;
            end else if (a.req0_valid) begin
                g0 = 1'b1;
            end else if (a.req1_valid) begin
                g1 = 1'b1;
            end
        end
        e1 = g0 ? a.req0_op1 : (g1 ? a.req1_op1 : 32'h0);
        e2 = g0 ? a.req0_op2 : (g1 ? a.req1_op2 : 32'h0);
        chk("req0_ready", {31'b0, a.req0_ready}, {31'b0, g0});
        chk("req1_ready", {31'b0, a.req1_ready}, {31'b0, g1});
        chk("fpu_op1", a.fpu_op1, e1);
        chk("fpu_op2", a.fpu_op2, e2);
        chk("busy", {31'b0, a.busy}, {31'b0, !blk && sb.size() > 0});

        ev = 1'b0;
        e  = '{due: 0, id: 1'b0, data: 32'h0};
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e  = sb.pop_front();
            ev = !blk;
        end
        chk("resp_valid", {31'b0, a.resp_valid}, {31'b0, ev});
        if (ev) begin
            chk("resp_id", {31'b0, a.resp_id}, {31'b0, e.id});
            chk("resp_data", a.resp_data, e.data);
        end else begin
            chk("resp_data_idle", a.resp_data, 32'h0);
            if (blk) chk("resp_id_reset", {31'b0, a.resp_id}, 32'h0);
        end

        if (g0 || g1) begin
            if (g0) ed = a.req0_sub ? fsub_f(a.req0_op1, a.req0_op2) : fadd_f(a.req0_op1, a.req0_op2);
            else    ed = a.req1_sub ? fsub_f(a.req1_op1, a.req1_op2) : fadd_f(a.req1_op1, a.req1_op2);
            sb.push_back('{due: cyc + int'(L), id: g1, data: ed});
            m_last = g1;
        end

        if (l4_k >= 0) begin
            chk("l4_ready", {31'b0, b.req0_ready}, {31'b0, l4_k == 0});
            chk("l4_resp_valid", {31'b0, b.resp_valid}, {31'b0, l4_k == 4});
            chk("l4_busy", {31'b0, b.busy}, {31'b0, l4_k >= 1 && l4_k <= 4});
            if (l4_k == 4) chk("l4_resp_data", b.resp_data, 32'h1234_5678);
        end

        @(posedge clk);
        rst_seen = !reset;
        if (!reset) begin
            sb.delete();
            m_last = 1'b1;
        end
        if (l4_k >= 0) l4_k++;
        cyc++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b1, 32'h1, 32'h2, 1'b0, 1'b1, 32'h3, 32'h4, 1'b1);
        b.req0_valid = 1'b0; b.req0_op1 = 32'h0; b.req0_op2 = 32'h0; b.req0_sub = 1'b0;
        b.req1_valid = 1'b0; b.req1_op1 = 32'h0; b.req1_op2 = 32'h0; b.req1_sub = 1'b0;

        // Reset with requests pending, then the quiet cycle after release.
        tick();
        tick();
        reset = 1'b1;
        tick();
        idle();
        tick();

        // Single requester 0 add, then single requester 1 subtract.
        drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        repeat (3) tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        tick();
        idle();
        repeat (3) tick();

        // Contention straight after reset: grants 0,1,0,1 back to back.
        reset = 1'b0;
        drive(1'b1, 32'h1000, 32'h2000, 1'b0, 1'b1, 32'h3000, 32'h4000, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + i, 32'h2000 + 3 * i, i[0], 1'b1, 32'h3000 + i,
                  32'h4000 + 5 * i, ~i[0]);
            tick();
        end
        idle();
        repeat (3) tick();

        // Idle cycle must not move the pointer.
        drive(1'b1, 32'h0A0A_0000, 32'h0000_0B0B, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b1, 32'h5555_0001, 32'h1111_0002, 1'b1, 1'b1, 32'h7777_0003, 32'h2222_0004, 1'b0);
        tick();
        tick();
        idle();
        repeat (3) tick();

        // Reset one cycle after a grant discards it.
        drive(1'b1, 32'h6666_0000, 32'h0000_6666, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (4) tick();

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            tick();
        end
        idle();
        repeat (3) tick();

        // LATENCY=4 instance: single issue, response four cycles later.
        b.req0_valid = 1'b1;
        b.req0_op1   = 32'h4120_0000;
        b.req0_op2   = 32'h3F00_0000;
        l4_k         = 0;
        tick();
        b.req0_valid = 1'b0;
        repeat (6) tick();
        l4_k = -1;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
